// File: rtl/rtc_pkg.sv
// rtc_pkg: command codes, field widths, limits and payload positions shared by the RTC timekeeper.
package rtc_pkg;
    typedef enum logic [2:0] {
        CMD_ALARM_CTRL      = 3'b000,
        CMD_SET_ALARM_MIN   = 3'b001,
        CMD_RESET_TIME      = 3'b010,
        CMD_SET_MS          = 3'b011,
        CMD_SET_ALARM_HOURS = 3'b100,
        CMD_SET_SEC         = 3'b101,
        CMD_SET_MIN         = 3'b110,
        CMD_SET_HOURS       = 3'b111
    } cmd_type_e;
    localparam int HOURS_W = 5;
    localparam int MIN_W = 6;
    localparam int SEC_W = 6;
    localparam int MS_W = 10;
    localparam int DATA_W = 10;
    localparam int HOURS_LIM = 24;
    localparam int MIN_LIM = 60;
    localparam int SEC_LIM = 60;
    localparam int MS_LIM = 1000;
    localparam int HOURS_LSB = 5;
    localparam int MIN_LSB = 4;
    localparam int SEC_LSB = 4;
    localparam int ALARM_EN_BIT = 0;
    localparam int ALARM_CLR_BIT = 1;
    function automatic logic is_time_cmd(cmd_type_e t);
        return t inside {CMD_SET_HOURS, CMD_SET_MIN, CMD_SET_SEC, CMD_SET_MS, CMD_RESET_TIME};
    endfunction
endpackage

// File: rtl/rtc_timekeeper_if.sv
// rtc_timekeeper_if: command bus into the timekeeper and the time/alarm outputs it drives.
interface rtc_timekeeper_if import rtc_pkg::*; #(parameter int DAY_W = 9) ();
    logic cmd_valid_i;
    cmd_type_e cmd_type_i;
    logic [DATA_W-1:0] cmd_data_i;
    logic [HOURS_W-1:0] hours_o;
    logic [MIN_W-1:0] minutes_o;
    logic [SEC_W-1:0] seconds_o;
    logic [MS_W-1:0] milliseconds_o;
    logic [DAY_W-1:0] day_o;
    logic alarm_o;
    modport master (
        output cmd_valid_i, cmd_type_i, cmd_data_i,
        input hours_o, minutes_o, seconds_o, milliseconds_o, day_o, alarm_o
    );
    modport slave (
        input cmd_valid_i, cmd_type_i, cmd_data_i,
        output hours_o, minutes_o, seconds_o, milliseconds_o, day_o, alarm_o
    );
endinterface

// File: rtl/rtc_prescaler.sv
// rtc_prescaler: divides the system clock into a one-cycle millisecond tick; clear_i restarts the count.
module rtc_prescaler #(parameter int MS_TICK_DIV = 1) (
    input logic clk_i,
    input logic srst_i,
    input logic clear_i,
    output logic tick_o
);
    localparam int CW = MS_TICK_DIV > 1 ? $clog2(MS_TICK_DIV) : 1;
    logic [CW-1:0] cnt_q;
    assign tick_o = cnt_q == CW'(MS_TICK_DIV - 1);
    always_ff @(posedge clk_i) begin
        if (srst_i || clear_i) cnt_q <= '0;
        else cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
    end
endmodule

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: h:m:s.ms clock with settable alarm and day counter.
// Day counter is built only when RTC_DAY_COUNT_EN is defined; otherwise day_o is tied to 0.
module rtc_timekeeper import rtc_pkg::*; #(
    parameter int MS_TICK_DIV = 1,
    parameter int DAY_W = 9
) (
    input logic clk_i,
    input logic srst_i,
    rtc_timekeeper_if.slave bus
);
    logic pre_tick, time_cmd, tick;
    logic set_h, set_m, set_s, set_ms, rst_time, set_ah, set_am, ctrl;
    logic ms_wrap, sec_wrap, min_wrap, hr_wrap, sec_carry, min_carry, hr_carry;
    logic alarm_hit, alarm_en_q, alarm_en_d, alarm_q, alarm_d;
    logic [HOURS_W-1:0] hr_q, hr_d, alarm_h_q, alarm_h_d;
    logic [MIN_W-1:0] min_q, min_d, alarm_m_q, alarm_m_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [MS_W-1:0] ms_q, ms_d;
    logic [DATA_W-1:0] data;
    assign data = bus.cmd_data_i;
    assign set_h = bus.cmd_valid_i && bus.cmd_type_i == CMD_SET_HOURS;
    assign set_m = bus.cmd_valid_i && bus.cmd_type_i == CMD_SET_MIN;
    assign set_s = bus.cmd_valid_i && bus.cmd_type_i == CMD_SET_SEC;
    assign set_ms = bus.cmd_valid_i && bus.cmd_type_i == CMD_SET_MS;
    assign rst_time = bus.cmd_valid_i && bus.cmd_type_i == CMD_RESET_TIME;
    assign set_ah = bus.cmd_valid_i && bus.cmd_type_i == CMD_SET_ALARM_HOURS;
    assign set_am = bus.cmd_valid_i && bus.cmd_type_i == CMD_SET_ALARM_MIN;
    assign ctrl = bus.cmd_valid_i && bus.cmd_type_i == CMD_ALARM_CTRL;
    assign time_cmd = bus.cmd_valid_i && is_time_cmd(bus.cmd_type_i);
    rtc_prescaler #(.MS_TICK_DIV(MS_TICK_DIV)) u_prescaler (
        .clk_i(clk_i),
        .srst_i(srst_i),
        .clear_i(time_cmd),
        .tick_o(pre_tick)
    );
    // A time write owns the cycle: the pending tick is dropped, not deferred.
    assign tick = pre_tick && !time_cmd;
    assign ms_wrap = ms_q == MS_W'(MS_LIM - 1);
    assign sec_wrap = sec_q == SEC_W'(SEC_LIM - 1);
    assign min_wrap = min_q == MIN_W'(MIN_LIM - 1);
    assign hr_wrap = hr_q == HOURS_W'(HOURS_LIM - 1);
    assign sec_carry = tick && ms_wrap;
    assign min_carry = sec_carry && sec_wrap;
    assign hr_carry = min_carry && min_wrap;
    assign ms_d = rst_time ? '0 : set_ms ? MS_W'(data % MS_LIM) : tick ? (ms_wrap ? '0 : ms_q + 1'b1) : ms_q;
    assign sec_d = rst_time ? '0 : set_s ? SEC_W'(data[DATA_W-1:SEC_LSB] % SEC_LIM) :
                   sec_carry ? (sec_wrap ? '0 : sec_q + 1'b1) : sec_q;
    assign min_d = rst_time ? '0 : set_m ? MIN_W'(data[DATA_W-1:MIN_LSB] % MIN_LIM) :
                   min_carry ? (min_wrap ? '0 : min_q + 1'b1) : min_q;
    assign hr_d = rst_time ? '0 : set_h ? HOURS_W'(data[DATA_W-1:HOURS_LSB] % HOURS_LIM) :
                  hr_carry ? (hr_wrap ? '0 : hr_q + 1'b1) : hr_q;
    assign alarm_h_d = set_ah ? HOURS_W'(data[DATA_W-1:HOURS_LSB] % HOURS_LIM) : alarm_h_q;
    assign alarm_m_d = set_am ? MIN_W'(data[DATA_W-1:MIN_LSB] % MIN_LIM) : alarm_m_q;
    assign alarm_en_d = ctrl ? data[ALARM_EN_BIT] : alarm_en_q;
    // Only a tick can land on the alarm time; tick is already low whenever time is written.
    assign alarm_hit = alarm_en_q && tick && hr_d == alarm_h_q && min_d == alarm_m_q && sec_d == '0 && ms_d == '0;
    assign alarm_d = alarm_hit || (alarm_q && !(ctrl && data[ALARM_CLR_BIT]));
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            hr_q <= '0;
            min_q <= '0;
            sec_q <= '0;
            ms_q <= '0;
            alarm_h_q <= '0;
            alarm_m_q <= '0;
            alarm_en_q <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            hr_q <= hr_d;
            min_q <= min_d;
            sec_q <= sec_d;
            ms_q <= ms_d;
            alarm_h_q <= alarm_h_d;
            alarm_m_q <= alarm_m_d;
            alarm_en_q <= alarm_en_d;
            alarm_q <= alarm_d;
        end
    end
`ifdef RTC_DAY_COUNT_EN
    logic [DAY_W-1:0] day_q;
    always_ff @(posedge clk_i) begin
        if (srst_i || rst_time) day_q <= '0;
        else day_q <= day_q + DAY_W'(hr_carry && hr_wrap);
    end
    assign bus.day_o = day_q;
`else
    assign bus.day_o = '0;
`endif
    assign bus.hours_o = hr_q;
    assign bus.minutes_o = min_q;
    assign bus.seconds_o = sec_q;
    assign bus.milliseconds_o = ms_q;
    assign bus.alarm_o = alarm_q;
endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb_rtc_timekeeper: table-driven set/modulo vectors plus hand sequences for carry, alarm and reset corners.
module tb_rtc_timekeeper;
    import rtc_pkg::*;
    localparam int DIV = 4;
    localparam int DAY_W = 9;
`ifdef RTC_DAY_COUNT_EN
    localparam logic [DAY_W-1:0] DAY1 = 1;
`else
    localparam logic [DAY_W-1:0] DAY1 = 0;
`endif
    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [9:0] ms;
        logic [DAY_W-1:0] day;
        logic al;
    } state_t;
    typedef struct {
        string name;
        state_t exp;
    } sb_t;
    typedef struct {
        cmd_type_e t;
        logic [9:0] d;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [9:0] ms;
    } vec_t;
    logic clk = 1'b0;
    logic srst;
    sb_t sb_q[$];
    vec_t vecs[13];
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    rtc_timekeeper_if #(.DAY_W(DAY_W)) bus ();
    rtc_timekeeper #(.MS_TICK_DIV(DIV), .DAY_W(DAY_W)) dut (
        .clk_i(clk),
        .srst_i(srst),
        .bus(bus)
    );
    function automatic state_t st(int h, int m, int s, int ms, logic [DAY_W-1:0] day, logic al);
        return '{5'(h), 6'(m), 6'(s), 10'(ms), day, al};
    endfunction
    task automatic push(string n, state_t e);
        sb_t r;
        r.name = n;
        r.exp = e;
        sb_q.push_back(r);
    endtask
    task automatic pop_check();
        sb_t r;
        state_t a;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got empty queue, want a pending expectation");
            return;
        end
        r = sb_q.pop_front();
        a = '{bus.hours_o, bus.minutes_o, bus.seconds_o, bus.milliseconds_o, bus.day_o, bus.alarm_o};
        if (a !== r.exp) begin
            errors++;
            $display("FAIL %s: got %0d:%0d:%0d.%0d day=%0d alarm=%0d, want %0d:%0d:%0d.%0d day=%0d alarm=%0d",
                     r.name, a.h, a.m, a.s, a.ms, a.day, a.al, r.exp.h, r.exp.m, r.exp.s, r.exp.ms, r.exp.day, r.exp.al);
        end
    endtask
    task automatic expect_at(string n, int cyc, state_t e);
        push(n, e);
        repeat (cyc) @(negedge clk);
        pop_check();
    endtask
    task automatic cmd(cmd_type_e t, logic [9:0] d);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_type_i = t;
        bus.cmd_data_i = d;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
    endtask
    initial begin
        vecs[0] = '{CMD_RESET_TIME, 10'd0, 5'd0, 6'd0, 6'd0, 10'd0};
        vecs[1] = '{CMD_SET_HOURS, 10'd991, 5'd6, 6'd0, 6'd0, 10'd0};
        vecs[2] = '{CMD_SET_MIN, 10'd991, 5'd6, 6'd1, 6'd0, 10'd0};
        vecs[3] = '{CMD_SET_SEC, 10'd1008, 5'd6, 6'd1, 6'd3, 10'd0};
        vecs[4] = '{CMD_SET_MS, 10'd1023, 5'd6, 6'd1, 6'd3, 10'd23};
        vecs[5] = '{CMD_RESET_TIME, 10'd1023, 5'd0, 6'd0, 6'd0, 10'd0};
        vecs[6] = '{CMD_SET_HOURS, 10'd992, 5'd7, 6'd0, 6'd0, 10'd0};
        vecs[7] = '{CMD_SET_MS, 10'd1000, 5'd7, 6'd0, 6'd0, 10'd0};
        vecs[8] = '{CMD_SET_MIN, 10'd1008, 5'd7, 6'd3, 6'd0, 10'd0};
        vecs[9] = '{CMD_SET_HOURS, 10'd736, 5'd23, 6'd3, 6'd0, 10'd0};
        vecs[10] = '{CMD_SET_MIN, 10'd944, 5'd23, 6'd59, 6'd0, 10'd0};
        vecs[11] = '{CMD_SET_SEC, 10'd944, 5'd23, 6'd59, 6'd59, 10'd0};
        vecs[12] = '{CMD_SET_MS, 10'd998, 5'd23, 6'd59, 6'd59, 10'd998};
        srst = 1'b1;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_type_i = CMD_ALARM_CTRL;
        bus.cmd_data_i = '0;
        repeat (3) @(negedge clk);
        srst = 1'b0;
        expect_at("reset_state", 0, st(0, 0, 0, 0, 0, 0));
        expect_at("ms_after_4", 4, st(0, 0, 0, 1, 0, 0));
        expect_at("ms_after_1000", 996, st(0, 0, 0, 250, 0, 0));
        expect_at("sec_after_4000", 3000, st(0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 13; i++) begin
            bus.cmd_valid_i = 1'b1;
            bus.cmd_type_i = vecs[i].t;
            bus.cmd_data_i = vecs[i].d;
            push($sformatf("vec%0d", i), st(vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].ms, 0, 0));
            @(negedge clk);
            pop_check();
        end
        bus.cmd_valid_i = 1'b0;
        expect_at("pre_midnight", 4, st(23, 59, 59, 999, 0, 0));
        expect_at("midnight_wrap", 4, st(0, 0, 0, 0, DAY1, 0));
        cmd(CMD_SET_ALARM_HOURS, 10'd224);
        cmd(CMD_SET_ALARM_MIN, 10'd480);
        cmd(CMD_ALARM_CTRL, 10'd1);
        cmd(CMD_SET_HOURS, 10'd224);
        cmd(CMD_SET_MIN, 10'd464);
        cmd(CMD_SET_SEC, 10'd944);
        cmd(CMD_SET_MS, 10'd999);
        expect_at("pre_alarm", 0, st(7, 29, 59, 999, DAY1, 0));
        expect_at("alarm_fire", 4, st(7, 30, 0, 0, DAY1, 1));
        expect_at("alarm_held", 8, st(7, 30, 0, 2, DAY1, 1));
        cmd(CMD_ALARM_CTRL, 10'd3);
        expect_at("alarm_clear", 0, st(7, 30, 0, 2, DAY1, 0));
        cmd(CMD_SET_HOURS, 10'd224);
        cmd(CMD_SET_MIN, 10'd480);
        cmd(CMD_SET_SEC, 10'd0);
        cmd(CMD_SET_MS, 10'd0);
        expect_at("direct_set_no_alarm", 0, st(7, 30, 0, 0, DAY1, 0));
        expect_at("no_retrigger", 4, st(7, 30, 0, 1, DAY1, 0));
        cmd(CMD_SET_MIN, 10'd464);
        cmd(CMD_SET_SEC, 10'd944);
        cmd(CMD_SET_MS, 10'd999);
        repeat (3) @(negedge clk);
        cmd(CMD_ALARM_CTRL, 10'd3);
        expect_at("trigger_beats_clear", 0, st(7, 30, 0, 0, DAY1, 1));
        cmd(CMD_ALARM_CTRL, 10'd0);
        expect_at("disable_keeps_flag", 0, st(7, 30, 0, 0, DAY1, 1));
        cmd(CMD_SET_MS, 10'd999);
        repeat (3) @(negedge clk);
        cmd(CMD_SET_MIN, 10'd80);
        expect_at("cmd_beats_tick", 0, st(7, 5, 0, 999, DAY1, 1));
        expect_at("prescaler_restart", 3, st(7, 5, 0, 999, DAY1, 1));
        expect_at("tick_after_restart", 1, st(7, 5, 1, 0, DAY1, 1));
        srst = 1'b1;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_type_i = CMD_SET_HOURS;
        bus.cmd_data_i = 10'd320;
        @(negedge clk);
        srst = 1'b0;
        bus.cmd_valid_i = 1'b0;
        expect_at("srst_override", 0, st(0, 0, 0, 0, 0, 0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
